// File: rtl/parity_frame_checker.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, even parity, stop bit.
// Completed frames are held behind a valid/ready handshake; a frame arriving while one is still held is dropped.
module parity_frame_checker #(
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_tick,
  input  logic              rx_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                par_acc_q, par_acc_d;
  logic [DATA_W-1:0]   shift_reg_q, shift_reg_d;
  logic                perr_q, perr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
  logic                frame_done;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    par_acc_d    = par_acc_q;
    shift_reg_d  = shift_reg_q;
    perr_d       = perr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    frame_done   = 1'b0;

    if (bit_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_in) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_acc_d = 1'b0;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt_q == CNT_W'(i)) shift_reg_d[i] = rx_in;
          end
          par_acc_d = par_acc_q ^ rx_in;
          // Counter saturates on the last data bit so it never exceeds DATA_W-1.
          if (bit_cnt_q == LAST_BIT) state_d = PARITY;
          else                       bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PARITY: begin
          perr_d  = par_acc_q ^ rx_in;
          state_d = STOP;
        end
        STOP: begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d  = 1'b1;
        out_data_d   = shift_reg_d;
        parity_err_d = perr_q;
        frame_err_d  = ~rx_in;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      par_acc_q    <= 1'b0;
      shift_reg_q  <= '0;
      perr_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      par_acc_q    <= par_acc_d;
      shift_reg_q  <= shift_reg_d;
      perr_q       <= perr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
